// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath register file and its users.
package mips_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREGS_DEF = 8;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Address of the hardwired-zero register.
    localparam int REG_ZERO  = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit storage word with load enable and asynchronous active-low clear.
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// Register file with two combinational read ports, one write port, write-first
// bypass and a per-register busy scoreboard. Register 0 reads as zero, never busy.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    output logic             rs_busy,
    output logic             rt_busy,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic             wr_ok;
    logic             set_ok;
    logic             rs_byp;
    logic             rt_byp;
    logic [WIDTH-1:0] q [NREGS];
    logic [NREGS-1:0] busy;

    assign wr_ok  = we && (wr_addr != ZERO_ADDR);
    assign set_ok = issue_valid && (issue_rd != ZERO_ADDR);

    assign q[0] = '0;

    for (genvar g = 1; g < NREGS; g++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clock (clock),
            .rst_n (reset),
            .en    (wr_ok && (wr_addr == AW'(g))),
            .d     (wr_data),
            .q     (q[g])
        );
    end

    // A new issue to the register being written wins: that writer is still pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_ok && (issue_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_ok && (wr_addr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign rs_byp = wr_ok && (wr_addr == rs_addr);
    assign rt_byp = wr_ok && (wr_addr == rt_addr);

    assign rs_data = rs_byp ? wr_data : q[rs_addr];
    assign rt_data = rt_byp ? wr_data : q[rt_addr];

    assign rs_busy = !rs_byp && busy[rs_addr];
    assign rt_busy = !rt_byp && busy[rt_addr];

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: directed scenarios plus random traffic against an array model,
// and a 32x32 instance for the wide-parameter sweep.
module tb_mips_regfile;
    import mips_pkg::*;

    logic        clock;
    logic        reset;
    reg_addr_t   rs_addr, rt_addr, wr_addr, issue_rd;
    logic [15:0] rs_data, rt_data, wr_data;
    logic        rs_busy, rt_busy, we, issue_valid;

    logic        b_reset;
    logic [4:0]  b_rs_addr, b_rt_addr, b_wr_addr, b_issue_rd;
    logic [31:0] b_rs_data, b_rt_data, b_wr_data;
    logic        b_rs_busy, b_rt_busy, b_we, b_issue_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [15:0] m_mem  [8];
    bit          m_busy [8];

    mips_regfile dut (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd)
    );

    mips_regfile #(.WIDTH(32), .NREGS(32)) dut_w (
        .clock(clock), .reset(b_reset),
        .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
        .rs_data(b_rs_data), .rt_data(b_rt_data),
        .rs_busy(b_rs_busy), .rt_busy(b_rt_busy),
        .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .issue_valid(b_issue_valid), .issue_rd(b_issue_rd)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: architectural registers and pending-writer flags.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 0;
            end
        end else begin
            bit set;
            set = issue_valid && issue_rd != 0;
            if (we && wr_addr != 0) begin
                m_mem[wr_addr] = wr_data;
                m_busy[wr_addr] = 0;
            end
            if (set) m_busy[issue_rd] = 1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [15:0] e_rs, e_rt;
            bit          b_rs, b_rt, wr_live;
            wr_live = reset && we && wr_addr != 0;
            e_rs = !reset ? 16'h0 : (wr_live && wr_addr == rs_addr) ? wr_data : m_mem[rs_addr];
            e_rt = !reset ? 16'h0 : (wr_live && wr_addr == rt_addr) ? wr_data : m_mem[rt_addr];
            b_rs = reset && !(wr_live && wr_addr == rs_addr) && m_busy[rs_addr];
            b_rt = reset && !(wr_live && wr_addr == rt_addr) && m_busy[rt_addr];
            chk("cyc_rs_data", 32'(rs_data), 32'(e_rs));
            chk("cyc_rt_data", 32'(rt_data), 32'(e_rt));
            chk("cyc_rs_busy", 32'(rs_busy), 32'(b_rs));
            chk("cyc_rt_busy", 32'(rt_busy), 32'(b_rt));
        end
    end

    initial begin
        reset = 0; we = 0; wr_addr = 0; wr_data = 0; rs_addr = 0; rt_addr = 0;
        issue_valid = 0; issue_rd = 0;
        b_reset = 0; b_we = 0; b_wr_addr = 0; b_wr_data = 0; b_rs_addr = 0; b_rt_addr = 0;
        b_issue_valid = 0; b_issue_rd = 0;
        #2;
        chk("reset_rs_data", 32'(rs_data), 32'h0);
        #10;
        reset = 1; b_reset = 1;
        chk_en = 1;

        // Reset mid-cycle clears data and busy with no edge.
        step();
        we = 1; wr_addr = 3; wr_data = 16'hBEEF; issue_valid = 1; issue_rd = 5;
        step();
        we = 0; issue_valid = 0; rs_addr = 3; rt_addr = 5;
        #1;
        chk("pre_reset_r3", 32'(rs_data), 32'hBEEF);
        chk("pre_reset_busy5", 32'(rt_busy), 32'h1);
        reset = 0;
        #1;
        chk("async_reset_r3", 32'(rs_data), 32'h0);
        chk("async_reset_rs_busy", 32'(rs_busy), 32'h0);
        chk("async_reset_rt_busy", 32'(rt_busy), 32'h0);
        reset = 1;

        // Write/read and r0 discard.
        step();
        we = 1; wr_addr = 5; wr_data = 16'h1234;
        step();
        wr_addr = 0; wr_data = 16'hFFFF;
        step();
        we = 0; rs_addr = 5; rt_addr = 0;
        #1;
        chk("read_r5", 32'(rs_data), 32'h1234);
        chk("read_r0", 32'(rt_data), 32'h0);

        // Bypass on both ports, old value ignored.
        step();
        we = 1; wr_addr = 2; wr_data = 16'h1111;
        step();
        wr_data = 16'hA5A5; rs_addr = 2; rt_addr = 2;
        #1;
        chk("bypass_rs", 32'(rs_data), 32'hA5A5);
        chk("bypass_rt", 32'(rt_data), 32'hA5A5);

        // Scoreboard life cycle on r4.
        step();
        we = 0; issue_valid = 1; issue_rd = 4;
        step();
        issue_valid = 0; rs_addr = 4;
        for (int k = 0; k < 4; k++) begin
            #1 chk("busy_r4_held", 32'(rs_busy), 32'h1);
            step();
        end
        we = 1; wr_addr = 4; wr_data = 16'h0042;
        #1;
        chk("busy_r4_write_cycle", 32'(rs_busy), 32'h0);
        chk("data_r4_write_cycle", 32'(rs_data), 32'h0042);
        step();
        we = 0;
        #1;
        chk("busy_r4_after", 32'(rs_busy), 32'h0);
        chk("data_r4_after", 32'(rs_data), 32'h0042);

        // Simultaneous set and clear on r6; issue to r0 changes nothing.
        step();
        issue_valid = 1; issue_rd = 6;
        step();
        we = 1; wr_addr = 6; wr_data = 16'h0606; rs_addr = 6;
        step();
        we = 0; issue_valid = 0;
        #1;
        chk("set_wins_r6", 32'(rs_busy), 32'h1);
        issue_valid = 1; issue_rd = 0; rs_addr = 0; rt_addr = 6;
        step();
        issue_valid = 0;
        #1;
        chk("issue_r0_busy", 32'(rs_busy), 32'h0);
        chk("issue_r0_r6_kept", 32'(rt_busy), 32'h1);

        // Random traffic checked every cycle by the model.
        for (int n = 0; n < 600; n++) begin
            step();
            we          = 1'($urandom_range(0, 1));
            wr_addr     = 3'($urandom_range(0, 7));
            wr_data     = 16'($urandom);
            issue_valid = 1'($urandom_range(0, 2) == 0);
            issue_rd    = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rs_addr     = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rt_addr     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 0;
                #1 chk("rand_reset_rs", 32'(rs_data), 32'h0);
                chk("rand_reset_busy", 32'(rs_busy), 32'h0);
                reset = 1;
            end
        end
        step();
        we = 0; issue_valid = 0;

        // Wide instance: {i,i} into every register, then read back all pairs.
        for (int i = 0; i < 32; i++) begin
            b_we = 1; b_wr_addr = 5'(i); b_wr_data = {16'(i), 16'(i)};
            step();
        end
        b_we = 0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                logic [31:0] ei, ej;
                b_rs_addr = 5'(i); b_rt_addr = 5'(j);
                ei = (i == 0) ? 32'h0 : {16'(i), 16'(i)};
                ej = (j == 0) ? 32'h0 : {16'(j), 16'(j)};
                #1;
                chk("wide_rs", b_rs_data, ei);
                chk("wide_rt", b_rt_data, ej);
            end
        end
        chk("wide_busy", 32'({b_rs_busy, b_rt_busy}), 32'h0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

Parametrised register file for the MIPS datapath: `NREGS` registers of `WIDTH` bits, two combinational read ports, one synchronous write port and a per-register busy scoreboard. It generalises the fixed 16-bit flip-flop register into an addressable, enable-gated, bypassed store and sits between decode (reads and issue) and writeback (writes).

## Interface
- `WIDTH`, 16, data width of each register
- `NREGS`, 8, number of registers; power of two, at least 2
- `AW`, $clog2(NREGS), address width (derived; do not override)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `rs_addr`  in  AW  read port A address
- `rt_addr`  in  AW  read port B address
- `rs_data`  out  WIDTH  read port A data
- `rt_data`  out  WIDTH  read port B data
- `rs_busy`  out  1  register at `rs_addr` has a pending writer
- `rt_busy`  out  1  register at `rt_addr` has a pending writer
- `we`  in  1  write enable
- `wr_addr`  in  AW  write address
- `wr_data`  in  WIDTH  write data
- `issue_valid`  in  1  decode issues an instruction that will write `issue_rd`
- `issue_rd`  in  AW  destination register of the issued instruction

## Operation
- Reset (`reset`=0, asynchronous): all registers go to 0 and all busy bits go to 0 immediately. Read outputs reflect 0 with no clock edge. Reset takes effect at any point, including mid-write.
- Register 0 is hardwired to zero:
  - writes to address 0 are discarded;
  - `issue_rd`=0 never sets a busy bit;
  - reads of address 0 return 0 and busy 0.
- Write: on a rising edge with `we`=1 and `wr_addr`≠0, `reg[wr_addr]` takes `wr_data`. With `we`=0 every register holds.
- Read: combinational. `rs_data` = `reg[rs_addr]`, except for bypass.
- Bypass (write-first): if `we`=1, `wr_addr`≠0 and `wr_addr`=`rs_addr`, then `rs_data`=`wr_data` in the same cycle. The same rule applies to `rt`. Both ports may bypass simultaneously.
- Scoreboard: one busy bit per register, for registers 1..NREGS-1.
  - Set on an edge with `issue_valid`=1 and `issue_rd`≠0.
  - Cleared on an edge with `we`=1 and `wr_addr` equal to that register.
  - Set and clear of the same register on the same edge: set wins, because the new writer is still pending.
  - Set and clear of different registers on the same edge: both apply.
- Busy outputs:
  - `rs_busy` = `busy[rs_addr]`, masked to 0 when a write to `rs_addr` occurs in the same cycle (bypass covers that case). The same rule applies to `rt_busy`.
  - A write to a register that is not busy is legal. It updates data and leaves busy at 0.
- No overflow or wrap logic. Addresses are full-range and every value is valid.

## Timing
- Read latency is 0 cycles (combinational from address and write inputs).
- Write latency is 1 cycle: data is visible through storage from the edge after the write. Through bypass it is visible in the write cycle itself.
- Busy is set 1 edge after issue. `rs_busy` reads 1 in the cycle after issue and stays 1 until the cycle in which the matching write is presented.
- All state is updated on the rising edge of `clock`. `reset` is asynchronous on assertion; deassertion is assumed synchronised upstream.

## Structure
- Shared package `mips_pkg` holds:
  - default `WIDTH` and `NREGS`;
  - the `REG_ZERO` address constant;
  - the typedef `reg_addr_t` for register addresses.
- Sub-module `reg_word`: a `WIDTH`-bit register with enable and asynchronous active-low clear. It is the parametrised successor of the fixed 16-bit register and is instantiated once for each register 1..NREGS-1 via a generate loop.
- Scoreboard, bypass muxes and zero-masking live in the top module.

## Test plan
- Reset: write 0xBEEF to r3, then pulse `reset` low mid-cycle → `rs_data` for r3 is 0x0000 immediately, and all busy outputs are 0.
- Write/read and r0: write 0x1234 to r5 and 0xFFFF to r0; read rs=r5, rt=r0 next cycle → `rs_data`=0x1234, `rt_data`=0x0000.
- Bypass: in one cycle, `we`=1, `wr_addr`=r2, `wr_data`=0xA5A5, `rs_addr`=`rt_addr`=r2 → both ports read 0xA5A5 that cycle, with old storage value ignored.
- Scoreboard life cycle: issue `issue_rd`=r4 → `rs_busy`(r4)=1 next cycle and for 3 idle cycles; write r4=0x0042 → `rs_busy`=0 and `rs_data`=0x0042 in the write cycle, and `rs_busy` stays 0 afterwards.
- Simultaneous set/clear: with r6 busy, present write r6 and issue r6 on the same edge → r6 is still busy next cycle. Issue r0 → `busy` unchanged.
- Parameter sweep: `WIDTH`=32, `NREGS`=32; write `{i,i}` pattern to r1..r31; read back all pairs → all match, and r0=0.
